// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, FETCH_WIDTH lanes, one outstanding line refill; optional ICACHE_PERF_CNT_EN adds hit/miss counters.
// Latency: hits return one cycle after acceptance; a miss replays the bundle after its refill(s) complete.
// Backpressure: int_stall holds upstream while a refill is pending or ext_stall is high; the refill FSM runs through ext_stall.
module icache_dm #(
    parameter int FETCH_WIDTH = 2,
    parameter int NUM_SETS    = 64,
    parameter int LINE_WORDS  = 4,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [FETCH_WIDTH-1:0][ADDR_WIDTH-1:0] read_addr,
    input  logic [FETCH_WIDTH-1:0]                 read_addr_valid,
    input  logic                                   ext_stall,
    input  logic                                   ext_flush,
    output logic [FETCH_WIDTH-1:0][31:0]           read_instr,
    output logic [FETCH_WIDTH-1:0]                 valid_read,
    output logic [FETCH_WIDTH-1:0]                 miss,
    output logic                                   int_stall,
    output logic [FETCH_WIDTH-1:0][ADDR_WIDTH-1:0] prev_read_addr,
    output logic                                   mem_req_valid,
    input  logic                                   mem_req_ready,
    output logic [ADDR_WIDTH-1:0]                  mem_req_addr,
    input  logic                                   mem_resp_valid,
    input  logic [32*LINE_WORDS-1:0]               mem_resp_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]                            hit_count,
    output logic [31:0]                            miss_count
`endif
);

    // Address split: [1:0] byte, then word offset, set index, tag.
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(NUM_SETS);
    localparam int LSB_IDX = 2 + OFF_W;
    localparam int LSB_TAG = LSB_IDX + IDX_W;
    localparam int TAG_W   = ADDR_WIDTH - LSB_TAG;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, REPLAY} state_t;

    state_t state, state_nxt;
    logic   flush_pending;

    // Line storage.
    logic [NUM_SETS-1:0]     valid_q;
    logic [TAG_W-1:0]        tag_q  [NUM_SETS];
    logic [32*LINE_WORDS-1:0] data_q [NUM_SETS];

    // Replay bundle. rp_done marks lanes already resolved (hit or invalid) with
    // their word captured in rp_data, so a later refill that evicts their line
    // cannot undo them; this also stops two lanes on conflicting lines from
    // thrashing each other forever.
    logic [FETCH_WIDTH-1:0][ADDR_WIDTH-1:0] rp_addr;
    logic [FETCH_WIDTH-1:0]                 rp_vld;
    logic [FETCH_WIDTH-1:0]                 rp_done;
    logic [FETCH_WIDTH-1:0][31:0]           rp_data;
    logic [ADDR_WIDTH-1:0]                  req_addr;

    // Lookup path, shared by fresh bundles (IDLE) and the replay bundle.
    logic                                   in_replay;
    logic [FETCH_WIDTH-1:0][ADDR_WIDTH-1:0] lk_addr;
    logic [FETCH_WIDTH-1:0]                 lk_vld;
    logic [FETCH_WIDTH-1:0][IDX_W-1:0]      ln_idx;
    logic [FETCH_WIDTH-1:0][TAG_W-1:0]      ln_tag;
    logic [FETCH_WIDTH-1:0][OFF_W-1:0]      ln_off;
    logic [FETCH_WIDTH-1:0][31:0]           ln_word;
    logic [FETCH_WIDTH-1:0]                 ln_thit;
    logic [FETCH_WIDTH-1:0]                 lk_hit;
    logic [FETCH_WIDTH-1:0][31:0]           lk_instr;
    logic                                   any_miss;
    logic [ADDR_WIDTH-1:0]                  miss_line;

    logic accept;
    logic replay_go;
    logic lookup_fire;
    logic refill_we;
    logic [IDX_W-1:0] refill_idx;

    assign in_replay  = (state == REPLAY);
    assign lk_addr    = in_replay ? rp_addr : read_addr;
    assign lk_vld     = in_replay ? rp_vld  : read_addr_valid;

    // A flush in the same cycle discards the presented bundle rather than accepting it.
    assign accept      = (state == IDLE) && !ext_stall && !ext_flush;
    assign replay_go   = in_replay && !ext_stall && !ext_flush;
    assign lookup_fire = accept || replay_go;

    assign int_stall     = ext_stall || (state != IDLE);
    assign mem_req_valid = (state == REQ) && !reset;
    assign mem_req_addr  = req_addr;
    assign refill_we     = (state == WAIT) && mem_resp_valid;
    assign refill_idx    = req_addr[LSB_IDX +: IDX_W];

    // Per-lane tag compare and word select; invalid or already-captured lanes count as hits.
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            ln_idx[i]   = lk_addr[i][LSB_IDX +: IDX_W];
            ln_tag[i]   = lk_addr[i][LSB_TAG +: TAG_W];
            ln_off[i]   = lk_addr[i][2 +: OFF_W];
            ln_word[i]  = data_q[ln_idx[i]][{ln_off[i], 5'b0} +: 32];
            ln_thit[i]  = valid_q[ln_idx[i]] && (tag_q[ln_idx[i]] == ln_tag[i]);
            lk_hit[i]   = (in_replay && rp_done[i]) || !lk_vld[i] || ln_thit[i];
            lk_instr[i] = (in_replay && rp_done[i]) ? rp_data[i] : ln_word[i];
        end
    end

    assign any_miss = ~&lk_hit;

    // Line address of the lowest-index missing lane.
    always_comb begin
        miss_line = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (!lk_hit[i]) begin
                miss_line = {lk_addr[i][ADDR_WIDTH-1:LSB_IDX], {LSB_IDX{1'b0}}};
            end
        end
    end

    // Refill FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Refill FSM next-state: one outstanding request, replay unless a flush intervened.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && any_miss) state_nxt = REQ;
            REQ:     if (mem_req_ready) state_nxt = WAIT;
            WAIT:    if (mem_resp_valid) state_nxt = (flush_pending || ext_flush) ? IDLE : REPLAY;
            REPLAY: begin
                if (ext_flush)       state_nxt = IDLE;
                else if (!ext_stall) state_nxt = any_miss ? REQ : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A flush during an outstanding refill suppresses the replay; cleared on return to IDLE.
    always_ff @(posedge clk) begin
        if (reset || (state_nxt == IDLE))                        flush_pending <= 1'b0;
        else if (ext_flush && ((state == REQ) || (state == WAIT))) flush_pending <= 1'b1;
    end

    // Capture the bundle, resolved lanes and next refill line whenever a lookup misses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rp_addr  <= '0;
            rp_vld   <= '0;
            rp_done  <= '0;
            rp_data  <= '0;
            req_addr <= '0;
        end else if (lookup_fire && any_miss) begin
            req_addr <= miss_line;
            rp_done  <= lk_hit;
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (lk_hit[i]) rp_data[i] <= lk_instr[i];
            end
            if (accept) begin
                rp_addr <= read_addr;
                rp_vld  <= read_addr_valid;
            end
        end else if (ext_flush) begin
            rp_vld <= '0;
        end
    end

    // Valid bits: cleared in one cycle by reset, set by a refill.
    always_ff @(posedge clk) begin
        if (reset)          valid_q <= '0;
        else if (refill_we) valid_q[refill_idx] <= 1'b1;
    end

    // Tag and data arrays are written only by a refill and need no reset.
    always_ff @(posedge clk) begin
        if (!reset && refill_we) begin
            tag_q[refill_idx]  <= req_addr[LSB_TAG +: TAG_W];
            data_q[refill_idx] <= mem_resp_data;
        end
    end

    // Output registers: flush/reset clear, ext_stall holds, otherwise present hits or report misses.
    always_ff @(posedge clk) begin
        if (reset || ext_flush) begin
            valid_read     <= '0;
            miss           <= '0;
            read_instr     <= {FETCH_WIDTH{32'h23}};
            prev_read_addr <= '0;
        end else if (!ext_stall) begin
            valid_read <= '0;
            miss       <= '0;
            if (lookup_fire && !any_miss) begin
                valid_read     <= lk_vld;
                read_instr     <= lk_instr;
                prev_read_addr <= lk_addr;
            end else if (accept) begin
                miss <= ~lk_hit;
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    localparam int CNT_W = $clog2(FETCH_WIDTH + 1);
    logic [CNT_W-1:0] hit_lanes;

    // Valid lanes that hit on a freshly accepted bundle.
    always_comb begin
        hit_lanes = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (lk_vld[i] && lk_hit[i]) hit_lanes = hit_lanes + CNT_W'(1);
        end
    end

    // Wrapping counters; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (accept)                          hit_count  <= hit_count + 32'(hit_lanes);
            if ((state == REQ) && mem_req_ready) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Randomised and directed checks of icache_dm against a line-level cache model.
// Latency: checks hit data one cycle after acceptance and replay data after refills.
// Backpressure: acts as memory (random ready/response delays) and upstream (holds bundle while stalled).
module tb_icache_dm;

    localparam int FW = 2;
    localparam int NS = 64;
    localparam int LW = 4;
    localparam int AW = 32;
    localparam int LINE_BYTES = 4 * LW;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [FW-1:0][AW-1:0]  read_addr;
    logic [FW-1:0]          read_addr_valid;
    logic                   ext_stall;
    logic                   ext_flush;
    logic [FW-1:0][31:0]    read_instr;
    logic [FW-1:0]          valid_read;
    logic [FW-1:0]          miss;
    logic                   int_stall;
    logic [FW-1:0][AW-1:0]  prev_read_addr;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [AW-1:0]          mem_req_addr;
    logic                   mem_resp_valid;
    logic [32*LW-1:0]       mem_resp_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]            hit_count;
    logic [31:0]            miss_count;
`endif

    always #5 clk = ~clk;

    icache_dm #(.FETCH_WIDTH(FW), .NUM_SETS(NS), .LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .read_addr      (read_addr),
        .read_addr_valid(read_addr_valid),
        .ext_stall      (ext_stall),
        .ext_flush      (ext_flush),
        .read_instr     (read_instr),
        .valid_read     (valid_read),
        .miss           (miss),
        .int_stall      (int_stall),
        .prev_read_addr (prev_read_addr),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Backing memory: every word is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_3C3C;
    endfunction

    function automatic logic [32*LW-1:0] line_data(input logic [31:0] l);
        logic [32*LW-1:0] d;
        for (int k = 0; k < LW; k++) d[32*k +: 32] = mem_word(l + 32'(4 * k));
        return d;
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a - (a % 32'(LINE_BYTES));
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a / 32'(LINE_BYTES)) % 32'(NS));
    endfunction

    // Model: which line each set currently holds.
    logic [31:0] m_line [int];
    int unsigned m_hits = 0;
    int unsigned m_refills = 0;

    function automatic bit cached(input logic [31:0] a);
        return m_line.exists(set_of(a)) && (m_line[set_of(a)] == line_of(a));
    endfunction

    logic [FW-1:0][AW-1:0] cur_a;
    logic [FW-1:0]         cur_v;
    logic [FW-1:0]         exp_miss;
    logic [31:0]           exp_reqs [$];

    // Expected miss mask and refill sequence: repeatedly refill the lowest still-missing lane's line.
    task automatic plan();
        logic [FW-1:0] pend;
        logic [31:0]   l;
        exp_reqs.delete();
        for (int i = 0; i < FW; i++) begin
            pend[i] = cur_v[i] && !cached(cur_a[i]);
            if (cur_v[i] && !pend[i]) m_hits++;
        end
        exp_miss = pend;
        while (pend != '0) begin
            l = '0;
            for (int i = FW - 1; i >= 0; i--) if (pend[i]) l = line_of(cur_a[i]);
            exp_reqs.push_back(l);
            m_line[set_of(l)] = l;
            m_refills++;
            for (int j = 0; j < FW; j++) if (pend[j] && cached(cur_a[j])) pend[j] = 1'b0;
        end
    endtask

    task automatic check_final(input bit flushed);
        chk("final_miss", miss, '0);
        if (flushed) begin
            chk("flush_valid", valid_read, '0);
            for (int i = 0; i < FW; i++) chk("flush_instr", read_instr[i], 32'h23);
        end else begin
            chk("valid_read", valid_read, cur_v);
            for (int i = 0; i < FW; i++) begin
                if (cur_v[i]) begin
                    chk("read_instr", read_instr[i], mem_word(cur_a[i]));
                    chk("prev_addr", prev_read_addr[i], cur_a[i]);
                end
            end
        end
    endtask

    // Called at a negedge right after the bundle was driven; acts as memory until the cache is idle.
    task automatic finish(input bit flush_in_wait);
        int          rq;
        int          dly;
        bit          done;
        bit          flushed;
        bit          flush_next;
        logic [31:0] resp_line;
        rq = 0; dly = -1; done = 0; flushed = 0; flush_next = 0; resp_line = '0;
        @(negedge clk);
        if (exp_reqs.size() == 0) begin
            chk("hit_int_stall", int_stall, 1'b0);
            chk("hit_no_req", mem_req_valid, 1'b0);
            check_final(1'b0);
            return;
        end
        chk("miss_lanes", miss, exp_miss);
        chk("valid_on_miss", valid_read, '0);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            ext_flush      = 1'b0;
            if (!int_stall) begin
                done = 1;
            end else if (flush_next) begin
                ext_flush       = 1'b1;
                read_addr_valid = '0;
                flush_next      = 0;
                flushed         = 1;
            end else if (dly > 0) begin
                dly--;
            end else if (dly == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = line_data(resp_line);
                dly = -1;
            end else if (mem_req_valid && ($urandom_range(0, 1) == 1)) begin
                if (rq < exp_reqs.size()) chk("req_addr", mem_req_addr, exp_reqs[rq]);
                else                      chk("extra_req", rq, exp_reqs.size());
                resp_line     = mem_req_addr;
                mem_req_ready = 1'b1;
                rq++;
                dly = $urandom_range(0, 2);
                if (flush_in_wait && rq == 1) flush_next = 1;
            end
        end
        chk("done_in_budget", done, 1'b1);
        chk("refill_count", rq, exp_reqs.size());
        check_final(flushed);
    endtask

    task automatic send(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [FW-1:0] v, input bit flush_in_wait);
        cur_a[0] = a0;
        cur_a[1] = a1;
        cur_v    = v;
        read_addr       = cur_a;
        read_addr_valid = v;
        plan();
        finish(flush_in_wait);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
          | (32'($urandom_range(0, LW - 1)) << 2) | 32'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a0, a1;
        logic [FW-1:0] v;
        reset = 1'b1; read_addr = '0; read_addr_valid = '0; ext_stall = 1'b0; ext_flush = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid_read, '0);
        chk("rst_miss", miss, '0);
        for (int i = 0; i < FW; i++) begin
            chk("rst_instr", read_instr[i], 32'h23);
            chk("rst_prev", prev_read_addr[i], '0);
        end
        chk("rst_req", mem_req_valid, 1'b0);
`ifdef ICACHE_PERF_CNT_EN
        chk("rst_hit_count", hit_count, '0);
        chk("rst_miss_count", miss_count, '0);
`endif
        reset = 1'b0;
        chk("rst_int_stall", int_stall, 1'b0);

        // Cold line, then the same fetch hits.
        send(32'h100, 32'h104, 2'b11, 0);
        send(32'h100, 32'h104, 2'b11, 0);
        // Same set, different tag: one refill, lane 0 keeps its captured word; 0x100 then evicted.
        send(32'h100, 32'h2100, 2'b11, 0);
        send(32'h100, 32'h104, 2'b11, 0);
        // Two cold lines on different sets: two sequential refills.
        send(32'h200, 32'h310, 2'b11, 0);
        // Flush while waiting for the response: line still written, no replay.
        send(32'h400, 32'h404, 2'b11, 1);
        send(32'h400, 32'h404, 2'b11, 0);

        // Hit, then three stalled cycles with a new bundle presented: outputs hold.
        send(32'h200, 32'h204, 2'b11, 0);
        ext_stall = 1'b1;
        read_addr[0] = 32'h310;
        read_addr[1] = 32'h314;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_int_stall", int_stall, 1'b1);
            check_final(1'b0);
        end
        ext_stall = 1'b0;
        send(32'h310, 32'h314, 2'b11, 0);

        // Reset while a refill is outstanding; a stray response afterwards is ignored.
        cur_a[0] = 32'h800; cur_a[1] = 32'h804; cur_v = 2'b11;
        read_addr = cur_a; read_addr_valid = cur_v;
        plan();
        @(negedge clk);
        chk("rstmid_miss", miss, exp_miss);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rstmid_wait_stall", int_stall, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        read_addr_valid = '0;
        m_line.delete();
        m_hits = 0;
        m_refills = 0;
        chk("rstmid_int_stall", int_stall, 1'b0);
        chk("rstmid_valid", valid_read, '0);
        chk("rstmid_req", mem_req_valid, 1'b0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = line_data(32'h800);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        send(32'h800, 32'h804, 2'b11, 0);

        // Random bundles over a small pool of lines to mix hits, conflicts and multi-refills.
        for (int n = 0; n < 250; n++) begin
            a0 = rand_addr();
            a1 = ($urandom_range(0, 2) == 0) ? rand_addr() : a0 + 32'd4;
            v  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            send(a0, a1, v, 0);
        end

`ifdef ICACHE_PERF_CNT_EN
        chk("hit_count", hit_count, 64'(m_hits));
        chk("miss_count", miss_count, 64'(m_refills));
`endif
        read_addr_valid = '0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
